dmem_access_ctrl: RTL and testbench

- Load/store handshake controller directly downstream of the execution stage; sits between the execution unit and the data-memory port.
- Captures one memory operation per instruction and holds the DMEM request stable until the memory acknowledges it.
- Stalls the pipeline while the access is outstanding, returns load data with a valid pulse, and flags misaligned accesses, conflicting accesses and timeouts.

---
 rtl/simple_processor_pkg.sv | 30 +++
 rtl/dmem_timeout_cnt.sv | 39 +++
 rtl/dmem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor data-memory path.
//   DATA_WIDTH            : data/address width of the core
//   DMEM_TIMEOUT_DEFAULT  : default BUSY-cycle budget before a DMEM access is abandoned
//   dmem_state_t          : load/store controller states
//   dmem_err_t            : error codes reported on err_code_o
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } dmem_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_CONFLICT = 2'b11
  } dmem_err_t;

  // Word accesses only: the two byte-offset bits must be zero.
  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// BUSY-cycle counter for the DMEM access controller.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   clear   : synchronous clear (new access accepted)
//   enable  : count this cycle (controller is BUSY)
//   expired : this enabled cycle is the last one allowed (TIMEOUT_CYCLES-th BUSY cycle)
// TIMEOUT_CYCLES must be >= 1. The counter saturates at TIMEOUT_CYCLES.
module dmem_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // The count reflects completed BUSY cycles, so the limit is reached on the
  // cycle whose increment would take it to TIMEOUT_CYCLES. Flagging it here
  // lets the controller drop the request right after the last allowed cycle.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store handshake controller between the execution stage and the DMEM port.
// Accepts one word access per instruction, holds the DMEM request until ack,
// stalls the pipeline meanwhile, and reports misalignment, load/store conflict
// and timeout errors.
//   clk_i, arst_i                : clock, asynchronous active-high reset
//   ex_valid_i/load_i/store_i    : execution-stage instruction qualifiers
//   ex_addr_i, ex_wdata_i        : byte address and store data
//   dmem_req_o/addr_o/we_o/wdata_o : memory request (held stable while BUSY)
//   dmem_ack_i, dmem_rdata_i     : memory completion and read data
//   stall_o                      : hold upstream pipeline
//   done_o, load_valid_o         : completion pulses
//   load_data_o                  : last completed load data
//   err_o, err_code_o            : error pulse and sticky error code
module dmem_access_ctrl #(
  parameter int unsigned DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = simple_processor_pkg::DMEM_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_load_i,
  input  logic                  ex_store_i,
  input  logic [DATA_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  output logic                  dmem_req_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  load_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  import simple_processor_pkg::*;

  dmem_state_t state, state_next;

  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [DATA_WIDTH-1:0] load_data;
  dmem_err_t             err_code;

  logic      accept;
  logic      capture;
  logic      err_set;
  dmem_err_t err_next;
  logic      busy;
  logic      expired;
  logic      req;
  logic      stall;
  logic      done;
  logic      load_valid;
  logic      err;

  // Enable depends only on the state so the expired flag never feeds back
  // into the ack decision combinationally; an ack on the limit cycle still wins.
  assign busy = (state == BUSY);

  dmem_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk_i),
    .rst     (arst_i),
    .clear   (accept),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      load_data <= '0;
      err_code  <= ERR_NONE;
    end else begin
      state <= state_next;
      if (accept) begin
        addr  <= ex_addr_i;
        wdata <= ex_wdata_i;
        we    <= ex_store_i;
      end
      if (capture) begin
        load_data <= dmem_rdata_i;
      end
      if (err_set) begin
        err_code <= err_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    err_set    = 1'b0;
    err_next   = ERR_NONE;
    req        = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    load_valid = 1'b0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        // Stray acks are ignored here; only a memory instruction matters.
        if (ex_valid_i && (ex_load_i || ex_store_i)) begin
          if (ex_load_i && ex_store_i) begin
            state_next = ERR;
            err_set    = 1'b1;
            err_next   = ERR_CONFLICT;
          end else if (!word_aligned(ex_addr_i[1:0])) begin
            state_next = ERR;
            err_set    = 1'b1;
            err_next   = ERR_MISALIGN;
          end else begin
            state_next = BUSY;
            accept     = 1'b1;
            stall      = 1'b1;
          end
        end
      end

      BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_ack_i) begin
          capture    = !we;
          state_next = DONE;
        end else if (expired) begin
          state_next = ERR;
          err_set    = 1'b1;
          err_next   = ERR_TIMEOUT;
        end
      end

      DONE: begin
        // Upstream advances at the end of this cycle; the still-present
        // instruction must not be accepted a second time.
        done       = 1'b1;
        load_valid = !we;
        state_next = IDLE;
      end

      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dmem_req_o   = req;
  assign dmem_addr_o  = addr;
  assign dmem_we_o    = we && req;
  assign dmem_wdata_o = wdata;
  assign stall_o      = stall;
  assign done_o       = done;
  assign load_valid_o = load_valid;
  assign load_data_o  = load_data;
  assign err_o        = err;
  assign err_code_o   = err_code;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl (TIMEOUT_CYCLES = 4).
module tb_dmem_access_ctrl;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_load_i = 1'b0;
  logic        ex_store_i = 1'b0;
  logic [31:0] ex_addr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o;
  logic        done_o;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int passes = 0;

  // Reference state: what the held outputs must show.
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_ldata = '0;
  logic [1:0]  m_code  = '0;

  dmem_access_ctrl #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_load_i    (ex_load_i),
    .ex_store_i   (ex_store_i),
    .ex_addr_i    (ex_addr_i),
    .ex_wdata_i   (ex_wdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .load_valid_o (load_valid_o),
    .load_data_o  (load_data_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  // One instruction from cycle 0 (IDLE accept) until one idle cycle after
  // completion. Expected per-cycle outputs follow the timing rules directly:
  // legal ops request in cycles 1..last, finish in last+1; illegal ops
  // error in cycle 1. The stalled instruction stays on ex_* until it completes.
  // ack_at = 0 means no ack; ack_at beyond T lands after the timeout.
  task automatic run_op(input string tag, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata);
    logic       legal, acked, hold, fin;
    int         last;
    logic [1:0] code;
    logic [5:0] exp_ctl, got_ctl;
    legal = !(ld && st) && (addr[1:0] == 2'b00);
    acked = legal && (ack_at >= 1) && (ack_at <= T);
    last  = !legal ? 0 : (acked ? ack_at : T);
    code  = (ld && st) ? 2'b11 : (!legal ? 2'b01 : 2'b10);
    for (int c = 0; c < last + 3; c++) begin
      hold = (c == 0) || (legal && (c <= last + 1));
      ex_valid_i = hold;
      if (hold) begin
        ex_load_i  = ld;
        ex_store_i = st;
        ex_addr_i  = addr;
        ex_wdata_i = wdata;
      end else begin
        ex_load_i  = 1'($urandom);
        ex_store_i = 1'($urandom);
        ex_addr_i  = $urandom;
        ex_wdata_i = $urandom;
      end
      dmem_ack_i   = (ack_at != 0) && (c == ack_at);
      dmem_rdata_i = (c == ack_at) ? rdata : $urandom;
      fin = (c == last + 1);
      if (legal && c == 1) begin
        m_addr  = addr;
        m_wdata = wdata;
      end
      if (fin) begin
        if (acked) begin
          if (ld) m_ldata = rdata;
        end else begin
          m_code = code;
        end
      end
      exp_ctl = {legal && c >= 1 && c <= last,
                 st && legal && c >= 1 && c <= last,
                 legal && c <= last,
                 acked && fin,
                 acked && ld && fin,
                 !acked && fin};
      @(negedge clk_i);
      got_ctl = {dmem_req_o, dmem_we_o, stall_o, done_o, load_valid_o, err_o};
      checks++;
      if (got_ctl !== exp_ctl)
        $display("FAIL %s cyc%0d ctl{req,we,stall,done,lv,err}: got %b want %b", tag, c, got_ctl, exp_ctl);
      else passes++;
      checks++;
      if ({dmem_addr_o, dmem_wdata_o} !== {m_addr, m_wdata})
        $display("FAIL %s cyc%0d addr/wdata: got %h/%h want %h/%h", tag, c, dmem_addr_o, dmem_wdata_o, m_addr, m_wdata);
      else passes++;
      checks++;
      if (load_data_o !== m_ldata)
        $display("FAIL %s cyc%0d load_data: got %h want %h", tag, c, load_data_o, m_ldata);
      else passes++;
      checks++;
      if (err_code_o !== m_code)
        $display("FAIL %s cyc%0d err_code: got %b want %b", tag, c, err_code_o, m_code);
      else passes++;
      @(posedge clk_i);
      #1;
    end
    ex_valid_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 arst_i = 1'b1;
    #2;
    checks++;
    if ({dmem_req_o, dmem_we_o, stall_o, done_o, load_valid_o, err_o, err_code_o} !== 8'h00)
      $display("FAIL reset ctl: got %b want 00000000",
               {dmem_req_o, dmem_we_o, stall_o, done_o, load_valid_o, err_o, err_code_o});
    else passes++;
    checks++;
    if ({dmem_addr_o, dmem_wdata_o, load_data_o} !== 96'h0)
      $display("FAIL reset data: got %h/%h/%h want 0/0/0", dmem_addr_o, dmem_wdata_o, load_data_o);
    else passes++;
    @(negedge clk_i);
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_aligned_store();
    run_op("store", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0BAD_F00D);
  endtask

  task automatic test_load_wait();
    run_op("load_wait", 1'b1, 1'b0, 32'h0000_0020, 32'h5555_AAAA, 4, 32'h1234_5678);
  endtask

  task automatic test_misaligned();
    run_op("misalign", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);
  endtask

  task automatic test_ack_at_limit();
    run_op("ack_limit", 1'b1, 1'b0, 32'h0000_0044, 32'h0, T, 32'hCAFE_0001);
  endtask

  task automatic test_conflict_and_stray();
    run_op("conflict", 1'b1, 1'b1, 32'h0000_0050, 32'h0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = $urandom;
      @(negedge clk_i);
      checks++;
      if ({done_o, load_valid_o, dmem_req_o, stall_o} !== 4'b0000)
        $display("FAIL stray_ack cyc%0d {done,lv,req,stall}: got %b want 0000", c,
                 {done_o, load_valid_o, dmem_req_o, stall_o});
      else passes++;
      @(posedge clk_i);
      #1;
    end
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (load_data_o !== m_ldata)
      $display("FAIL stray_ack load_data: got %h want %h", load_data_o, m_ldata);
    else passes++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_non_mem();
    ex_valid_i = 1'b1;
    ex_load_i  = 1'b0;
    ex_store_i = 1'b0;
    ex_addr_i  = 32'h0000_0060;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if ({dmem_req_o, stall_o, done_o, err_o} !== 4'b0000)
        $display("FAIL non_mem cyc%0d {req,stall,done,err}: got %b want 0000", c,
                 {dmem_req_o, stall_o, done_o, err_o});
      else passes++;
      @(posedge clk_i);
      #1;
    end
    ex_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    ex_valid_i = 1'b1;
    ex_load_i  = 1'b1;
    ex_store_i = 1'b0;
    ex_addr_i  = 32'h0000_0080;
    @(posedge clk_i);
    #1;
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dmem_req_o !== 1'b1) $display("FAIL rst_busy req_before: got %b want 1", dmem_req_o);
    else passes++;
    @(posedge clk_i);
    #2 arst_i = 1'b1;
    #1;
    m_addr = '0; m_wdata = '0; m_ldata = '0; m_code = '0;
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00)
      $display("FAIL rst_busy async {req,stall}: got %b want 00", {dmem_req_o, stall_o});
    else passes++;
    @(negedge clk_i);
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFEED_FACE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if ({done_o, load_valid_o, load_data_o} !== {2'b00, m_ldata})
        $display("FAIL rst_busy late_ack cyc%0d {done,lv,data}: got %b%b %h want 00 %h", c,
                 done_o, load_valid_o, load_data_o, m_ldata);
      else passes++;
      @(posedge clk_i);
      #1;
      dmem_ack_i = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        ld, st;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      ld   = 1'($urandom);
      st   = !ld;
      a[1:0] = 2'b00;
      if (kind == 0) begin
        ld = 1'b1;
        st = 1'b1;
      end else if (kind == 1) begin
        a[1:0] = 2'($urandom_range(1, 3));
      end
      run_op("random", ld, st, a, $urandom, $urandom_range(0, T + 2), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_load_wait();
    test_misaligned();
    test_timeout();
    test_ack_at_limit();
    test_conflict_and_stray();
    test_non_mem();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
